// File: rtl/key_matrix_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: frame result
// classification, debounce FSM state encoding and matrix geometry.
package key_matrix_scanner_pkg;

   localparam int KEY_ROWS = 4;
   localparam int KEY_COLS = 4;

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_SINGLE = 2'd1,
      RES_MULTI  = 2'd2
   } frame_res_t;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_PRESS_DEB = 2'd1;
   localparam logic [1:0] ST_PRESSED   = 2'd2;
   localparam logic [1:0] ST_REL_DEB   = 2'd3;

endpackage

// File: rtl/key_row_scanner.sv
// Row drive, column synchroniser and per-frame hit accumulation. Emits one
// classified result (none / single key / multiple keys) per full 4-row scan.
module key_row_scanner
   import key_matrix_scanner_pkg::*;
#(
   parameter logic [31:0] SCAN_DIV = 32'd100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_COLS-1:0] col_n_i,
   output logic [KEY_ROWS-1:0] row_n_o,
   output logic                frame_done_o,
   output logic [1:0]          frame_res_o,
   output logic [3:0]          frame_code_o
);

   logic [KEY_COLS-1:0] col_meta_q, col_s_q;
   logic [31:0]         slot_q;
   logic [1:0]          row_idx_q;
   logic [KEY_ROWS-1:0] row_n_q;
   logic [1:0]          hits_q;
   logic [3:0]          code_q;
   logic [1:0]          res_q;
   logic [3:0]          res_code_q;
   logic                res_stb_q, frame_done_q;

   logic                sample;
   logic [KEY_COLS-1:0] pressed;
   logic [2:0]          row_cnt, hits_sum;
   logic [1:0]          row_col, hits_nxt, row_nxt;
   logic [3:0]          code_nxt;

   // NOTE: every variable driven here gets a default first, so no latch can be inferred.
   always_comb begin
      sample   = (slot_q == SCAN_DIV - 32'd1);
      pressed  = ~col_s_q;
      row_nxt  = row_idx_q + 2'd1;
      row_cnt  = {2'b00, pressed[0]} + {2'b00, pressed[1]}
               + {2'b00, pressed[2]} + {2'b00, pressed[3]};
      row_col  = 2'd0;
      for (int c = KEY_COLS - 1; c >= 0; c--) begin
         if (pressed[c]) row_col = c[1:0];
      end
      hits_sum = {1'b0, hits_q} + row_cnt;
      hits_nxt = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
      code_nxt = (row_cnt != 3'd0) ? {row_idx_q, row_col} : code_q;
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_q   <= '1;
         col_s_q      <= '1;
         slot_q       <= '0;
         row_idx_q    <= '0;
         row_n_q      <= 4'b1110;
         hits_q       <= '0;
         code_q       <= '0;
         res_q        <= RES_NONE;
         res_code_q   <= '0;
         res_stb_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_meta_q   <= col_n_i;
         col_s_q      <= col_meta_q;
         res_stb_q    <= 1'b0;
         frame_done_q <= res_stb_q;
         if (sample) begin
            slot_q    <= '0;
            row_idx_q <= row_nxt;
            row_n_q   <= ~(4'b0001 << row_nxt);
            if (row_idx_q == 2'd3) begin
               // Last row closes the frame; the accumulator restarts empty.
               res_q      <= (hits_nxt == 2'd0) ? RES_NONE :
                             (hits_nxt == 2'd1) ? RES_SINGLE : RES_MULTI;
               res_code_q <= code_nxt;
               res_stb_q  <= 1'b1;
               hits_q     <= '0;
               code_q     <= '0;
            end else begin
               hits_q <= hits_nxt;
               code_q <= code_nxt;
            end
         end else begin
            slot_q <= slot_q + 32'd1;
         end
      end
   end

   assign row_n_o      = row_n_q;
   assign frame_done_o = frame_done_q;
   assign frame_res_o  = res_q;
   assign frame_code_o = res_code_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x4 keypad scanner top: debounces frame results into one press and one
// release event per physical key action; chords and second keys are ignored.
module key_matrix_scanner
   import key_matrix_scanner_pkg::*;
#(
   parameter logic [31:0] SCAN_DIV   = 32'd100000,
   parameter logic [3:0]  DEB_FRAMES = 4'd4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_COLS-1:0] col_n,
   output logic [KEY_ROWS-1:0] row_n,
   output logic [3:0]          key_code,
   output logic                key_valid,
   output logic                key_release,
   output logic                key_down
);

   logic       frame_done;
   logic [1:0] frame_res_raw;
   logic [3:0] frame_code;
   frame_res_t frame_res;

   key_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_row_scanner (
      .clk          (clk),
      .rst          (rst),
      .col_n_i      (col_n),
      .row_n_o      (row_n),
      .frame_done_o (frame_done),
      .frame_res_o  (frame_res_raw),
      .frame_code_o (frame_code)
   );

   assign frame_res = frame_res_t'(frame_res_raw);

   logic [1:0] state_q, state_d;
   logic [3:0] deb_q, deb_d, deb_inc;
   logic [3:0] cand_q, cand_d;
   logic [3:0] key_code_q, key_code_d;
   logic       key_valid_q, key_valid_d;
   logic       key_release_q, key_release_d;
   logic       key_down_q, key_down_d;

   always_comb begin
      state_d       = state_q;
      deb_d         = deb_q;
      cand_d        = cand_q;
      key_code_d    = key_code_q;
      key_down_d    = key_down_q;
      key_valid_d   = 1'b0;
      key_release_d = 1'b0;
      deb_inc       = deb_q + 4'd1;
      if (frame_done) begin
         case (state_q)
            ST_IDLE: begin
               if (frame_res == RES_SINGLE) begin
                  cand_d = frame_code;
                  deb_d  = 4'd1;
                  if (DEB_FRAMES == 4'd1) begin
                     state_d     = ST_PRESSED;
                     deb_d       = 4'd0;
                     key_code_d  = frame_code;
                     key_down_d  = 1'b1;
                     key_valid_d = 1'b1;
                  end else begin
                     state_d = ST_PRESS_DEB;
                  end
               end
            end
            ST_PRESS_DEB: begin
               if (frame_res == RES_SINGLE && frame_code == cand_q) begin
                  deb_d = deb_inc;
                  if (deb_inc == DEB_FRAMES) begin
                     state_d     = ST_PRESSED;
                     deb_d       = 4'd0;
                     key_code_d  = cand_q;
                     key_down_d  = 1'b1;
                     key_valid_d = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
                  deb_d   = 4'd0;
               end
            end
            ST_PRESSED: begin
               if (frame_res == RES_NONE) begin
                  deb_d = 4'd1;
                  if (DEB_FRAMES == 4'd1) begin
                     state_d       = ST_IDLE;
                     deb_d         = 4'd0;
                     key_down_d    = 1'b0;
                     key_release_d = 1'b1;
                  end else begin
                     state_d = ST_REL_DEB;
                  end
               end
            end
            ST_REL_DEB: begin
               if (frame_res == RES_NONE) begin
                  deb_d = deb_inc;
                  if (deb_inc == DEB_FRAMES) begin
                     state_d       = ST_IDLE;
                     deb_d         = 4'd0;
                     key_down_d    = 1'b0;
                     key_release_d = 1'b1;
                  end
               end else begin
                  state_d = ST_PRESSED;
                  deb_d   = 4'd0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         deb_q         <= '0;
         cand_q        <= '0;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_release_q <= 1'b0;
         key_down_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         deb_q         <= deb_d;
         cand_q        <= cand_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_release_q <= key_release_d;
         key_down_q    <= key_down_d;
      end
   end

   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_release = key_release_q;
   assign key_down    = key_down_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Scoreboard bench for key_matrix_scanner: directed keypad scenarios push
// expected press/release events; a monitor pops and compares each event.
module tb_key_matrix_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] col_n, row_n, key_code;
   logic       key_valid, key_release, key_down;
   logic [15:0] keys = 16'h0000;

   typedef struct packed {
      logic       rel;
      logic [3:0] code;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   always #5 clk = ~clk;

   // Keypad model: a pressed key shorts its column low while its row is driven.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   key_matrix_scanner #(.SCAN_DIV(32'd4), .DEB_FRAMES(4'd3)) dut (
      .clk         (clk),
      .rst         (rst),
      .col_n       (col_n),
      .row_n       (row_n),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_release (key_release),
      .key_down    (key_down)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input logic rel, input logic [3:0] code);
      exp_q.push_back({rel, code});
   endtask

   task automatic drain(input string name);
      check(name, exp_q.size(), 0);
   endtask

   // Returns at the negedge just after row 0 becomes active again.
   task automatic next_frame();
      logic [3:0] prev;
      bit seen;
      prev = row_n;
      seen = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (row_n == 4'b1110 && prev == 4'b0111) seen = 1;
         prev = row_n;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL frame_timeout: got no frame start expected one within 64 cycles");
      end
   endtask

   task automatic frames(input int n);
      repeat (n) next_frame();
   endtask

   // Monitor: every press/release pulse must match the head of the queue.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (!rst && (key_valid || key_release)) begin
            check("valid_release_exclusive", {31'd0, key_valid & key_release}, 0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: got valid=%0b release=%0b code=%0h expected none",
                        key_valid, key_release, key_code);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", {31'd0, key_release}, {31'd0, e.rel});
               check("event_code", {28'd0, key_code}, {28'd0, e.code});
               check("event_key_down", {31'd0, key_down}, {31'd0, ~e.rel});
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_row_n", row_n, 4'b1110);
      check("rst_key_code", key_code, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_release", key_release, 0);
      check("rst_key_down", key_down, 0);
      rst = 1'b0;

      // 1: idle scanning, rows rotate every SCAN_DIV clocks
      for (int i = 0; i < 40; i++) begin
         logic [3:0] exp_row;
         exp_row = ~(4'b0001 << ((i / 4) % 4));
         check("row_n_seq", row_n, exp_row);
         @(negedge clk);
      end
      frames(8);
      check("idle_key_down", key_down, 0);
      drain("idle_no_events");

      // 2: clean press and release of key (2,1)
      expect_ev(1'b0, 4'd9);
      expect_ev(1'b1, 4'd9);
      keys = 16'h1 << 9;
      frames(6);
      check("hold_key_down", key_down, 1);
      check("hold_key_code", key_code, 9);
      keys = 16'h0;
      frames(5);
      check("released_key_down", key_down, 0);
      check("released_key_code_held", key_code, 9);
      drain("press_release_9");

      // 3: bouncing key (0,3) never reaches three stable frames
      keys = 16'h1 << 3;  frames(2);
      keys = 16'h0;       frames(1);
      keys = 16'h1 << 3;  frames(2);
      keys = 16'h0;       frames(2);
      drain("bounce_no_valid");
      expect_ev(1'b0, 4'd3);
      expect_ev(1'b1, 4'd3);
      keys = 16'h1 << 3;
      frames(4);
      check("bounce_then_hold_down", key_down, 1);
      check("bounce_then_hold_code", key_code, 3);
      keys = 16'h0;
      frames(4);
      drain("press_release_3");

      // 4: same-row chord is rejected; second key while pressed is ignored
      keys = (16'h1 << 4) | (16'h1 << 6);
      frames(5);
      check("chord_key_down", key_down, 0);
      drain("chord_no_valid");
      keys = 16'h0;
      frames(2);
      expect_ev(1'b0, 4'd15);
      keys = 16'h1 << 15;
      frames(4);
      check("held_15_code", key_code, 15);
      keys = (16'h1 << 15) | 16'h1;
      frames(3);
      check("second_key_code_held", key_code, 15);
      check("second_key_down", key_down, 1);
      expect_ev(1'b1, 4'd15);
      keys = 16'h0;
      frames(5);
      drain("press_release_15");

      // 5: key reappears during release debounce
      expect_ev(1'b0, 4'd15);
      keys = 16'h1 << 15;
      frames(4);
      keys = 16'h0;        frames(2);
      keys = 16'h1 << 15;  frames(1);
      check("glitch_still_down", key_down, 1);
      expect_ev(1'b1, 4'd15);
      keys = 16'h0;
      frames(2);
      check("release_not_early", key_down, 1);
      check("release_pending", exp_q.size(), 1);
      frames(2);
      check("glitch_released", key_down, 0);
      drain("glitch_single_release");

      // 6: asynchronous reset while (1,1) is held
      expect_ev(1'b0, 4'd5);
      keys = 16'h1 << 5;
      frames(4);
      check("pre_reset_down", key_down, 1);
      check("pre_reset_code", key_code, 5);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_key_down", key_down, 0);
      check("async_rst_key_code", key_code, 0);
      check("async_rst_key_valid", key_valid, 0);
      check("async_rst_key_release", key_release, 0);
      check("async_rst_row_n", row_n, 4'b1110);
      @(negedge clk);
      rst = 1'b0;
      expect_ev(1'b0, 4'd5);
      frames(4);
      drain("post_reset_valid");
      check("post_reset_code", key_code, 5);
      expect_ev(1'b1, 4'd5);
      keys = 16'h0;
      frames(5);
      drain("post_reset_release");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
